// File: rtl/fp_mul_iter_if.sv
// Request/response bundle for fp_mul_iter: operands and rounding mode in,
// product and IEEE exception flags out, each side under valid/ready.
interface fp_mul_iter_if #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [2:0]   rounding_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_invalid;
  logic         flag_overflow;
  logic         flag_underflow;
  logic         flag_inexact;

  modport master (
    output in_valid, operand_a, operand_b, rounding_mode, out_ready,
    input  in_ready, out_valid, result,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  in_valid, operand_a, operand_b, rounding_mode, out_ready,
    output in_ready, out_valid, result,
           flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fp_mul_iter.sv
// Sequential IEEE-754 binary multiplier: shift-add significand product, MUL_BITS
// multiplier bits per cycle, then one cycle of normalise/round/saturate.
module fp_mul_iter #(
  parameter int EXP_W    = 11,
  parameter int MAN_W    = 52,
  parameter int MUL_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_iter_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int N      = (SIG_W + MUL_BITS - 1) / MUL_BITS;
  localparam int MR_W   = N * MUL_BITS;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LZ_W   = $clog2(SIG_W + 1);
  localparam int SE_W   = EXP_W + 3;
  localparam int SH_MAX = MAN_W + 2;
  localparam int SH_W   = $clog2(SH_MAX + 1);
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [SE_W-1:0] BIAS_S   = SE_W'(BIAS);
  localparam logic signed [SE_W-1:0] ONE_S    = SE_W'(1);
  localparam logic signed [SE_W-1:0] EMAX_S   = SE_W'((1 << EXP_W) - 1);
  localparam logic signed [SE_W-1:0] SHMAX_S  = SE_W'(SH_MAX);
  localparam logic signed [SE_W-1:0] SUBEXP_S = SE_W'(1 - BIAS);

  localparam logic [W-2:0] QNAN_BODY = {{EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] INF_BODY  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-2:0] MAXF_BODY = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_ROUND, S_DONE} state_t;
  typedef enum logic [2:0] {RM_RNE = 3'd0, RM_RTZ = 3'd1, RM_RDN = 3'd2,
                            RM_RUP = 3'd3, RM_RMM = 3'd4} rm_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  typedef struct packed {
    logic             sign;
    logic             nan;
    logic             inf;
    logic             zero;
    logic [SE_W-1:0]  uexp;  // unbiased, two's complement
    logic [SIG_W-1:0] sig;   // normalised: MSB set unless zero
  } opnd_t;

  function automatic logic [LZ_W-1:0] count_lz(input logic [SIG_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) n = LZ_W'(SIG_W - 1 - i);
    return n;
  endfunction

  function automatic opnd_t decode(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic [LZ_W-1:0]  lz;
    opnd_t            o;
    e      = x[W-2 -: EXP_W];
    f      = x[MAN_W-1:0];
    o.sign = x[W-1];
    o.nan  = (&e) & (|f);
    o.inf  = (&e) & ~(|f);
    o.zero = ~(|e) & ~(|f);
    lz     = (|e) ? '0 : count_lz({1'b0, f});
    o.sig  = {|e, f} << lz;
    o.uexp = (|e) ? (SE_W'(e) - BIAS_S) : (SUBEXP_S - SE_W'(lz));
    return o;
  endfunction

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, b_q;
  rm_t                    mode_q;
  logic                   sign_q;
  logic signed [SE_W-1:0] exp_sum_q;
  logic [PROD_W-1:0]      acc_q, md_q;
  logic [MR_W-1:0]        mr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [W-1:0]           result_q;
  flags_t                 flags_q;
  logic                   in_ready, out_valid;

  // ---------------- FSM ----------------
  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every always_ff samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  opnd_t   da, db;
  logic    special;
  logic    last_iter;
  logic [W-1:0] spc_result;
  flags_t  spc_flags;

  assign da        = decode(a_q);
  assign db        = decode(b_q);
  assign last_iter = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_UNPACK;
      S_UNPACK: state_d = special ? S_DONE : S_MUL;
      S_MUL:    if (last_iter) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = rst_n;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------- special operands ----------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case chain can leave a latch behind.
  always_comb begin
    special     = 1'b1;
    spc_flags   = '0;
    spc_result  = '0;
    if (da.nan | db.nan) begin
      spc_result        = {da.sign ^ db.sign, QNAN_BODY};
      spc_flags.invalid = 1'b1;
    end else if ((da.zero & db.inf) | (da.inf & db.zero)) begin
      spc_result        = {1'b0, QNAN_BODY};
      spc_flags.invalid = 1'b1;
    end else if (da.zero | db.zero) begin
      spc_result = {da.sign ^ db.sign, {(W-1){1'b0}}};
    end else if (da.inf | db.inf) begin
      spc_result = {da.sign ^ db.sign, INF_BODY};
    end else begin
      special = 1'b0;
    end
  end

  // ---------------- shift-add step ----------------
  logic [PROD_W-1:0] partial;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++)
      if (mr_q[j]) partial = partial + (md_q << j);
  end

  // ---------------- normalise / round ----------------
  logic [PROD_W-1:0]      nprod, shifted;
  logic signed [SE_W-1:0] be_pre, sh_full, exp_fin;
  logic [SH_W-1:0]        sh;
  logic [SIG_W-1:0]       sig;
  logic [SIG_W:0]         sig_r;
  logic                   tiny, lost, g, r, s, inexact, round_up, ovf, to_inf;
  logic [W-1:0]           rnd_result;
  flags_t                 rnd_flags;

  always_comb begin
    nprod   = acc_q[PROD_W-1] ? acc_q : (acc_q << 1);
    be_pre  = exp_sum_q + BIAS_S + SE_W'(acc_q[PROD_W-1]);
    tiny    = (be_pre < ONE_S);
    sh_full = ONE_S - be_pre;
    sh      = '0;
    if (tiny) sh = (sh_full > SHMAX_S) ? SH_W'(SH_MAX) : sh_full[SH_W-1:0];
    // Subnormal range: denormalise, folding everything shifted off into sticky.
    shifted = nprod >> sh;
    lost    = |(nprod & ~({PROD_W{1'b1}} << sh));
    sig     = shifted[PROD_W-1 -: SIG_W];
    g       = shifted[SIG_W-1];
    r       = shifted[SIG_W-2];
    s       = (|shifted[SIG_W-3:0]) | lost;
    inexact = g | r | s;

    case (mode_q)
      RM_RNE:  round_up = g & (sig[0] | r | s);
      RM_RDN:  round_up = inexact & sign_q;
      RM_RUP:  round_up = inexact & ~sign_q;
      RM_RMM:  round_up = g;
      default: round_up = 1'b0;
    endcase

    sig_r   = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
    // A subnormal that rounds into the hidden bit lands on exponent field 1.
    exp_fin = (tiny ? SE_W'(sig_r[MAN_W]) : be_pre) + SE_W'(sig_r[SIG_W]);
    ovf     = (exp_fin >= EMAX_S);
    to_inf  = (mode_q == RM_RNE) | (mode_q == RM_RMM) |
              ((mode_q == RM_RUP) & ~sign_q) | ((mode_q == RM_RDN) & sign_q);

    if (ovf) rnd_result = {sign_q, to_inf ? INF_BODY : MAXF_BODY};
    else     rnd_result = {sign_q, exp_fin[EXP_W-1:0], sig_r[MAN_W-1:0]};

    rnd_flags.invalid   = 1'b0;
    rnd_flags.overflow  = ovf;
    rnd_flags.underflow = tiny & inexact;
    rnd_flags.inexact   = inexact | ovf;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= RM_RNE;
      sign_q    <= 1'b0;
      exp_sum_q <= '0;
      acc_q     <= '0;
      md_q      <= '0;
      mr_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          a_q    <= bus.operand_a;
          b_q    <= bus.operand_b;
          mode_q <= rm_t'(bus.rounding_mode);
        end
        S_UNPACK: begin
          sign_q    <= da.sign ^ db.sign;
          exp_sum_q <= $signed(da.uexp) + $signed(db.uexp);
          md_q      <= PROD_W'(da.sig);
          mr_q      <= MR_W'(db.sig);
          acc_q     <= '0;
          cnt_q     <= '0;
          if (special) begin
            result_q <= spc_result;
            flags_q  <= spc_flags;
          end
        end
        S_MUL: begin
          acc_q <= acc_q + partial;
          md_q  <= md_q << MUL_BITS;
          mr_q  <= mr_q >> MUL_BITS;
          cnt_q <= cnt_q + 1'b1;
        end
        S_ROUND: begin
          result_q <= rnd_result;
          flags_q  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.result         = result_q;
  assign bus.flag_invalid   = flags_q.invalid;
  assign bus.flag_overflow  = flags_q.overflow;
  assign bus.flag_underflow = flags_q.underflow;
  assign bus.flag_inexact   = flags_q.inexact;
endmodule
